// File: rtl/bp_pkg.sv
// Types and constants shared between the branch update queue and the branch predictor.
package bp_pkg;

   localparam int unsigned IDX_W = 8;

   // One resolved branch, as handed from EX to the predictor update port
   typedef struct packed {
      logic             taken;
      logic             mispredict;
      logic [IDX_W-1:0] pc_idx;
      logic [IDX_W-1:0] target;
   } buq_entry_t;

   localparam int unsigned ENTRY_W = $bits(buq_entry_t);

   // 2-bit saturating direction counter encodings
   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } bp_ctr_e;

   function automatic bp_ctr_e ctr_next(input bp_ctr_e cur, input logic taken);
      bp_ctr_e nxt;
      nxt = cur;
      if (taken && (cur != CTR_ST)) begin
         nxt = bp_ctr_e'(2'(cur) + 2'd1);
      end else if (!taken && (cur != CTR_SNT)) begin
         nxt = bp_ctr_e'(2'(cur) - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_update_queue_if.sv
// EX-side push port and predictor-side update port of the branch update queue.
// Statistics signals exist only when BUQ_STATS_EN is defined.
interface branch_update_queue_if
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = 4
`ifdef BUQ_STATS_EN
   , parameter int unsigned CNT_W = 32
`endif
);

   logic                     flush;
   logic                     br_valid;
   logic                     br_ready;
   logic                     br_taken;
   logic                     br_mispredict;
   logic [IDX_W-1:0]         br_pc_idx;
   logic [IDX_W-1:0]         br_target;
   logic                     upd_hold;
   logic                     branch;
   logic                     branch_res;
   logic                     branch_fail;
   logic [IDX_W-1:0]         branch_addr;
   logic [IDX_W-1:0]         branch_target;
   logic [$clog2(DEPTH):0]   q_count;
`ifdef BUQ_STATS_EN
   logic [CNT_W-1:0]         stat_branches;
   logic [CNT_W-1:0]         stat_mispred;
`endif

   // Queue side
   modport slave (
      input  flush, br_valid, br_taken, br_mispredict, br_pc_idx, br_target, upd_hold,
      output br_ready, branch, branch_res, branch_fail, branch_addr, branch_target, q_count
`ifdef BUQ_STATS_EN
      , output stat_branches, stat_mispred
`endif
   );

   // EX / predictor side
   modport master (
      output flush, br_valid, br_taken, br_mispredict, br_pc_idx, br_target, upd_hold,
      input  br_ready, branch, branch_res, branch_fail, branch_addr, branch_target, q_count
`ifdef BUQ_STATS_EN
      , input stat_branches, stat_mispred
`endif
   );

endinterface

// File: rtl/buq_mem.sv
// Entry storage for the branch update queue: one write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the queue pointers.
module buq_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 18
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [W-1:0]             i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [W-1:0]             o_rdata
);

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/branch_update_queue.sv
// In-order FIFO from EX branch resolution to the predictor update port; one pop per cycle.
// Define BUQ_STATS_EN to add popped-branch and mispredict counters.
module branch_update_queue
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = 4
`ifdef BUQ_STATS_EN
   , parameter int unsigned CNT_W = 32
`endif
) (
   input  logic                  clk,
   input  logic                  resetn,
   branch_update_queue_if.slave  bus
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned QCNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [QCNT_W-1:0] r_count;

   logic       w_full;
   logic       w_empty;
   logic       w_push;
   logic       w_pop;
   logic       w_we;
   buq_entry_t w_wdata;
   buq_entry_t w_head;

   // Full blocks pushes even when the head pops in the same cycle
   assign w_full  = (r_count == QCNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = bus.br_valid & ~w_full;
   assign w_pop   = ~w_empty & ~bus.upd_hold;
   assign w_we    = w_push & ~bus.flush;

   assign w_wdata = '{taken:      bus.br_taken,
                      mispredict: bus.br_mispredict,
                      pc_idx:     bus.br_pc_idx,
                      target:     bus.br_target};

   buq_mem #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_head)
   );

   // Pointers and occupancy; flush overrides any push/pop in the same cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + QCNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - QCNT_W'(1);
         end
      end
   end

   assign bus.br_ready      = ~w_full;
   assign bus.branch        = w_pop;
   assign bus.branch_res    = w_head.taken;
   assign bus.branch_fail   = w_head.mispredict;
   assign bus.branch_addr   = w_head.pc_idx;
   assign bus.branch_target = w_head.target;
   assign bus.q_count       = r_count;

`ifdef BUQ_STATS_EN
   logic [CNT_W-1:0] r_stat_branches;
   logic [CNT_W-1:0] r_stat_mispred;

   // A pop presented during a flush cycle is not counted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stat_branches <= '0;
         r_stat_mispred  <= '0;
      end else if (w_pop && !bus.flush) begin
         r_stat_branches <= r_stat_branches + CNT_W'(1);
         if (w_head.mispredict) begin
            r_stat_mispred <= r_stat_mispred + CNT_W'(1);
         end
      end
   end

   assign bus.stat_branches = r_stat_branches;
   assign bus.stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: reset, ordering, full, push+pop, flush, async reset, stats.
module tb_branch_update_queue;
   import bp_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pops   = 0;

   always #5 clk = ~clk;

   branch_update_queue_if #(
      .DEPTH (DEPTH)
`ifdef BUQ_STATS_EN
      , .CNT_W (32)
`endif
   ) bus ();

   branch_update_queue #(
      .DEPTH (DEPTH)
`ifdef BUQ_STATS_EN
      , .CNT_W (32)
`endif
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // target is pc ^ 0xF0 so payload checks can use hand-computed constants
   task automatic drive(input logic v, input logic [7:0] pc, input logic tk, input logic mp);
      bus.br_valid      = v;
      bus.br_pc_idx     = pc;
      bus.br_target     = pc ^ 8'hF0;
      bus.br_taken      = tk;
      bus.br_mispredict = mp;
   endtask

   initial begin
      bus.flush    = 1'b0;
      bus.upd_hold = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_q_count", 32'(bus.q_count), 32'd0);
      chk("rst_branch", 32'(bus.branch), 32'd0);
      chk("rst_br_ready", 32'(bus.br_ready), 32'd1);
`ifdef BUQ_STATS_EN
      chk("rst_stat_branches", bus.stat_branches, 32'd0);
`endif
      resetn = 1'b1;
      cyc();

      // Ordering: three back-to-back pushes drain on three consecutive cycles
      drive(1'b1, 8'h10, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 8'h20, 1'b0, 1'b1);
      @(negedge clk);
      chk("ord0_branch", 32'(bus.branch), 32'd1);
      chk("ord0_addr", 32'(bus.branch_addr), 32'h10);
      chk("ord0_res", 32'(bus.branch_res), 32'd1);
      chk("ord0_fail", 32'(bus.branch_fail), 32'd0);
      chk("ord0_target", 32'(bus.branch_target), 32'hE0);
      chk("ord0_q", 32'(bus.q_count), 32'd1);
      cyc();
      drive(1'b1, 8'h30, 1'b1, 1'b0);
      @(negedge clk);
      chk("ord1_branch", 32'(bus.branch), 32'd1);
      chk("ord1_addr", 32'(bus.branch_addr), 32'h20);
      chk("ord1_res", 32'(bus.branch_res), 32'd0);
      chk("ord1_fail", 32'(bus.branch_fail), 32'd1);
      chk("ord1_q", 32'(bus.q_count), 32'd1);
      cyc();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("ord2_branch", 32'(bus.branch), 32'd1);
      chk("ord2_addr", 32'(bus.branch_addr), 32'h30);
      chk("ord2_res", 32'(bus.branch_res), 32'd1);
      chk("ord2_target", 32'(bus.branch_target), 32'hC0);
      cyc();
      @(negedge clk);
      chk("ord_empty_branch", 32'(bus.branch), 32'd0);
      chk("ord_empty_q", 32'(bus.q_count), 32'd0);

      // Full: hold the predictor, offer five entries, only four land
      cyc();
      bus.upd_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
         @(negedge clk);
         chk("full_ready", 32'(bus.br_ready), (i < 4) ? 32'd1 : 32'd0);
         cyc();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("full_q", 32'(bus.q_count), 32'd4);
      chk("full_branch_held", 32'(bus.branch), 32'd0);
      cyc();
      bus.upd_hold = 1'b0;
      n_pops = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.branch) begin
            chk("drain_addr", 32'(bus.branch_addr), 32'(n_pops + 1));
            n_pops++;
         end
         cyc();
      end
      chk("drain_pops", 32'(n_pops), 32'd4);
      chk("drain_q", 32'(bus.q_count), 32'd0);

      // Simultaneous push and pop at count==1
      drive(1'b1, 8'h44, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 8'h55, 1'b1, 1'b0);
      @(negedge clk);
      chk("sim_head", 32'(bus.branch_addr), 32'h44);
      chk("sim_q_before", 32'(bus.q_count), 32'd1);
      cyc();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("sim_q_after", 32'(bus.q_count), 32'd1);
      chk("sim_branch", 32'(bus.branch), 32'd1);
      chk("sim_addr", 32'(bus.branch_addr), 32'h55);
      cyc();
      @(negedge clk);
      chk("sim_empty_q", 32'(bus.q_count), 32'd0);

      // Flush with a push and a pop in the flush cycle
      cyc();
      bus.upd_hold = 1'b1;
      drive(1'b1, 8'h61, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 8'h62, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 8'h63, 1'b0, 1'b0);
      cyc();
      bus.upd_hold = 1'b0;
      bus.flush    = 1'b1;
      drive(1'b1, 8'h64, 1'b0, 1'b0);
      @(negedge clk);
      chk("fl_q_before", 32'(bus.q_count), 32'd3);
      chk("fl_branch_during", 32'(bus.branch), 32'd1);
      chk("fl_addr_during", 32'(bus.branch_addr), 32'h61);
      cyc();
      bus.flush = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("fl_q_after", 32'(bus.q_count), 32'd0);
      chk("fl_branch_after", 32'(bus.branch), 32'd0);
      chk("fl_ready_after", 32'(bus.br_ready), 32'd1);
      cyc();
      @(negedge clk);
      chk("fl_push_lost", 32'(bus.q_count), 32'd0);

      // Asynchronous reset with three entries queued
      cyc();
      bus.upd_hold = 1'b1;
      drive(1'b1, 8'h71, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 8'h72, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 8'h73, 1'b0, 1'b0);
      cyc();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      bus.upd_hold = 1'b0;
      #1;
      chk("ar_q_pre", 32'(bus.q_count), 32'd3);
      chk("ar_branch_pre", 32'(bus.branch), 32'd1);
`ifdef BUQ_STATS_EN
      // 3 + 4 + 2 pops so far, flush-cycle pop excluded; only 0x20 mispredicted
      chk("ar_stat_branches_pre", bus.stat_branches, 32'd9);
      chk("ar_stat_mispred_pre", bus.stat_mispred, 32'd1);
`endif
      resetn = 1'b0;
      #1;
      chk("ar_q", 32'(bus.q_count), 32'd0);
      chk("ar_branch", 32'(bus.branch), 32'd0);
      chk("ar_ready", 32'(bus.br_ready), 32'd1);
`ifdef BUQ_STATS_EN
      chk("ar_stat_branches", bus.stat_branches, 32'd0);
      chk("ar_stat_mispred", bus.stat_mispred, 32'd0);
`endif
      @(negedge clk);
      resetn = 1'b1;
      cyc();

      // Six entries streamed through, mispredict on the 2nd and 5th
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'(8'h80 + i), 1'(i & 1), 1'((i == 1) || (i == 4)));
         cyc();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("st_last_addr", 32'(bus.branch_addr), 32'h85);
      repeat (3) cyc();
      @(negedge clk);
      chk("st_q", 32'(bus.q_count), 32'd0);
`ifdef BUQ_STATS_EN
      chk("st_branches", bus.stat_branches, 32'd6);
      chk("st_mispred", bus.stat_mispred, 32'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
